fp_max_pool: RTL and testbench

//  Streaming max-pool reducer for the tiny_nn datapath. Consumes fp_t samples over a

---
 rtl/tiny_nn_pkg.sv | 23 ++
 rtl/fp_cmp.sv | 35 +++
 rtl/fp_max_pool.sv | 120 ++++++++++++
 tb/tb_fp_max_pool.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_nn_pkg.sv
// Shared types and helpers for the tiny_nn datapath: the fp_t binary32 layout,
// NaN/Inf classifiers and the max-pool FSM state type.
package tiny_nn_pkg;

  typedef struct packed {
    logic        sgn;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp_t;

  localparam fp_t FPZero = '0;

  typedef enum logic {MaxPoolAccum, MaxPoolOutput} max_pool_state_e;

  function automatic logic is_nan(input fp_t x);
    return (&x.exp) && (|x.man);
  endfunction

  function automatic logic is_inf(input fp_t x);
    return (&x.exp) && !(|x.man);
  endfunction

endpackage

// File: rtl/fp_cmp.sv
// Combinational fp_t comparator: gt_o is set when op_a_i is strictly greater than
// op_b_i. Signed-magnitude ordering puts +0 above -0. Any NaN operand raises
// invalid_o and forces gt_o low.
module fp_cmp
  import tiny_nn_pkg::*;
(
  input  fp_t  op_a_i,
  input  fp_t  op_b_i,
  output logic gt_o,
  output logic invalid_o
);

  logic [30:0] w_mag_a;
  logic [30:0] w_mag_b;
  logic        w_gt_raw;

  assign w_mag_a = {op_a_i.exp, op_a_i.man};
  assign w_mag_b = {op_b_i.exp, op_b_i.man};

  // Ordering on sign first, then magnitude (reversed when both are negative).
  always_comb begin
    w_gt_raw = 1'b0;
    if (op_a_i.sgn != op_b_i.sgn) begin
      w_gt_raw = !op_a_i.sgn;
    end else if (!op_a_i.sgn) begin
      w_gt_raw = (w_mag_a > w_mag_b);
    end else begin
      w_gt_raw = (w_mag_a < w_mag_b);
    end
  end

  assign invalid_o = is_nan(op_a_i) || is_nan(op_b_i);
  assign gt_o      = w_gt_raw && !invalid_o;

endmodule

// File: rtl/fp_max_pool.sv
// Streaming max-pool reducer: emits the maximum and its index for every WINDOW
// accepted samples, plus a flag if any sample was NaN.
// Optional build macro FP_MAX_POOL_RELU_EN clamps a negative non-NaN maximum to
// FPZero when the window closes (index and NaN flag are unaffected).
module fp_max_pool
  import tiny_nn_pkg::*;
#(
  parameter int unsigned  WINDOW = 4,
  localparam int unsigned IDX_W  = $clog2(WINDOW)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  fp_t              in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output fp_t              out_data_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_nan_o
);

  max_pool_state_e  r_state;
  max_pool_state_e  w_state_nxt;
  logic [IDX_W-1:0] r_count;
  fp_t              r_max;
  logic [IDX_W-1:0] r_idx;
  logic             r_nan;

  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic             w_gt;
  logic             w_invalid;
  logic             w_replace;
  fp_t              w_max_cand;
  fp_t              w_max_load;
  logic [IDX_W-1:0] w_idx_cand;
  logic             w_nan_cand;

  fp_cmp u_fp_cmp (
    .op_a_i    (in_data_i),
    .op_b_i    (r_max),
    .gt_o      (w_gt),
    .invalid_o (w_invalid)
  );

  assign w_accept = in_valid_i && in_ready_o;
  assign w_first  = (r_count == '0);
  assign w_last   = (r_count == IDX_W'(WINDOW - 1));

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= MaxPoolAccum;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; no overlap between accumulating and emitting.
  always_comb begin
    w_state_nxt = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (r_state)
      MaxPoolAccum: begin
        in_ready_o = 1'b1;
        if (in_valid_i && w_last) begin
          w_state_nxt = MaxPoolOutput;
        end
      end
      MaxPoolOutput: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          w_state_nxt = MaxPoolAccum;
        end
      end
    endcase
  end

  // Replacement decision: a NaN running max yields to any real sample, otherwise
  // only a strictly greater sample wins, so ties keep the earliest index.
  always_comb begin
    w_replace  = w_first ||
                 (is_nan(r_max) && !is_nan(in_data_i)) ||
                 (w_gt && !w_invalid);
    w_max_cand = w_replace ? in_data_i : r_max;
    w_idx_cand = w_replace ? r_count : r_idx;
    w_nan_cand = (w_first ? 1'b0 : r_nan) | is_nan(in_data_i);
    w_max_load = w_max_cand;
`ifdef FP_MAX_POOL_RELU_EN
    if (w_last && !is_nan(w_max_cand) && w_max_cand.sgn) begin
      w_max_load = FPZero;
    end
`else
    w_max_load = w_max_cand;
`endif
  end

  // Running max, index, NaN flag and sample counter; they double as the held result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
      r_max   <= FPZero;
      r_idx   <= '0;
      r_nan   <= 1'b0;
    end else if (w_accept) begin
      r_max   <= w_max_load;
      r_idx   <= w_idx_cand;
      r_nan   <= w_nan_cand;
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

  assign out_data_o = r_max;
  assign out_idx_o  = r_idx;
  assign out_nan_o  = r_nan;

endmodule

// File: tb/tb_fp_max_pool.sv
// Self-checking bench for fp_max_pool (WINDOW=4): directed scenarios plus
// randomized windows checked against a total-order reference model.
module tb_fp_max_pool;
  import tiny_nn_pkg::*;

  localparam logic [31:0] P1   = 32'h3F80_0000;  //  1.0
  localparam logic [31:0] P2   = 32'h4000_0000;  //  2.0
  localparam logic [31:0] P25  = 32'h4020_0000;  //  2.5
  localparam logic [31:0] P3   = 32'h4040_0000;  //  3.0
  localparam logic [31:0] P100 = 32'h42C8_0000;  //  100.0
  localparam logic [31:0] N1   = 32'hBF80_0000;  // -1.0
  localparam logic [31:0] N2   = 32'hC000_0000;  // -2.0
  localparam logic [31:0] N3   = 32'hC040_0000;  // -3.0
  localparam logic [31:0] N5   = 32'hC0A0_0000;  // -5.0
  localparam logic [31:0] PZ   = 32'h0000_0000;
  localparam logic [31:0] NZ   = 32'h8000_0000;
  localparam logic [31:0] NINF = 32'hFF80_0000;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  fp_t        in_data;
  logic       out_valid;
  logic       out_ready;
  fp_t        out_data;
  logic [1:0] out_idx;
  logic       out_nan;

  int checks;
  int errors;

  logic [31:0] win [4];

  fp_max_pool #(.WINDOW(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .out_nan_o   (out_nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit nan32(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  // Total-order key for non-NaN values: -0 sits just below +0.
  function automatic longint key32(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? (-mag - 1) : mag;
  endfunction

  // Reference: first occurrence of the largest non-NaN value; all-NaN -> sample 0.
  task automatic model(output logic [31:0] ed, output logic [1:0] ei, output logic en);
    int best;
    best = -1;
    en   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (nan32(win[i])) en = 1'b1;
      else if (best < 0 || key32(win[i]) > key32(win[best])) best = i;
    end
    if (best < 0) begin
      ed = win[0];
      ei = 2'd0;
    end else begin
      ed = win[best];
      ei = 2'(best);
`ifdef FP_MAX_POOL_RELU_EN
      if (ed[31]) ed = 32'h0;
`endif
    end
  endtask

  task automatic drive(input logic [31:0] d, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic send_window(input int max_gap);
    for (int i = 0; i < 4; i++) drive(win[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
  endtask

  // Wait (bounded) for a result, hold it for 'stall' cycles, capture, then accept it.
  task automatic collect(input int stall, output logic [31:0] d, output logic [1:0] i,
                         output logic n, output bit ok);
    ok = 1'b0;
    d  = '0;
    i  = '0;
    n  = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (stall) @(negedge clk);
      d = out_data;
      i = out_idx;
      n = out_nan;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== FPZero ||
        out_idx !== 2'd0 || out_nan !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got v=%b r=%b d=%h i=%0d n=%b want v=0 r=1 d=0 i=0 n=0",
               out_valid, in_ready, out_data, out_idx, out_nan);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] i; logic n; bit ok;
    win = '{P1, P3, N2, P25};
    for (int k = 0; k < 3; k++) drive(win[k], 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: got %b want 0", out_valid);
    end
    drive(win[3], 0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: out_valid got %b want 1 one cycle after last accept", out_valid);
    end
    collect(0, d, i, n, ok);
    checks++;
    if (!ok || d !== P3 || i !== 2'd1 || n !== 1'b0) begin
      errors++;
      $display("FAIL basic_max: got ok=%b d=%h i=%0d n=%b want d=%h i=1 n=0", ok, d, i, n, P3);
    end
  endtask

  task automatic test_ties();
    logic [31:0] d; logic [1:0] i; logic n; bit ok;
    win = '{P2, P2, P2, P2};
    send_window(0);
    collect(0, d, i, n, ok);
    checks++;
    if (!ok || d !== P2 || i !== 2'd0) begin
      errors++;
      $display("FAIL tie_earliest: got ok=%b d=%h i=%0d want d=%h i=0", ok, d, i, P2);
    end
    win = '{NZ, PZ, NZ, NZ};
    send_window(0);
    collect(0, d, i, n, ok);
    checks++;
    if (!ok || d !== PZ || i !== 2'd1) begin
      errors++;
      $display("FAIL signed_zero: got ok=%b d=%h i=%0d want d=%h i=1", ok, d, i, PZ);
    end
  endtask

  task automatic test_nan();
    logic [31:0] d; logic [1:0] i; logic n; bit ok; logic [31:0] exp_d;
`ifdef FP_MAX_POOL_RELU_EN
    exp_d = PZ;
`else
    exp_d = N1;
`endif
    win = '{QNAN, N1, QNAN, N5};
    send_window(0);
    collect(0, d, i, n, ok);
    checks++;
    if (!ok || d !== exp_d || i !== 2'd1 || n !== 1'b1) begin
      errors++;
      $display("FAIL nan_mixed: got ok=%b d=%h i=%0d n=%b want d=%h i=1 n=1",
               ok, d, i, n, exp_d);
    end
    win = '{32'h7FC0_0001, QNAN, 32'hFFC0_0000, QNAN};
    send_window(1);
    collect(0, d, i, n, ok);
    checks++;
    if (!ok || d !== 32'h7FC0_0001 || i !== 2'd0 || n !== 1'b1) begin
      errors++;
      $display("FAIL nan_all: got ok=%b d=%h i=%0d n=%b want d=7fc00001 i=0 n=1", ok, d, i, n);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] i; logic n; bit ok;
    win = '{N3, P25, P1, N2};
    send_window(0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== P25 ||
          out_idx !== 2'd1 || out_nan !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable c=%0d: got v=%b r=%b d=%h i=%0d n=%b want v=1 r=0 d=%h i=1 n=0",
                 c, out_valid, in_ready, out_data, out_idx, out_nan, P25);
      end
      in_valid = 1'b1;
      in_data  = P100;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    win = '{P1, N1, P2, N2};
    send_window(0);
    collect(0, d, i, n, ok);
    checks++;
    if (!ok || d !== P2 || i !== 2'd2 || n !== 1'b0) begin
      errors++;
      $display("FAIL after_stall: got ok=%b d=%h i=%0d n=%b want d=%h i=2 n=0", ok, d, i, n, P2);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d; logic [1:0] i; logic n; bit ok;
    drive(P100, 0);
    drive(QNAN, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== FPZero ||
        out_idx !== 2'd0 || out_nan !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b r=%b d=%h i=%0d n=%b want v=0 r=1 d=0 i=0 n=0",
               out_valid, in_ready, out_data, out_idx, out_nan);
    end
    @(negedge clk);
    rst = 1'b0;
    win = '{N1, N2, P1, P1};
    send_window(0);
    collect(0, d, i, n, ok);
    checks++;
    if (!ok || d !== P1 || i !== 2'd2 || n !== 1'b0) begin
      errors++;
      $display("FAIL fresh_window: got ok=%b d=%h i=%0d n=%b want d=%h i=2 n=0", ok, d, i, n, P1);
    end
    // Reset while a result is pending drops it.
    win = '{P3, P3, P3, P3};
    send_window(0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_output: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_relu();
    logic [31:0] d; logic [1:0] i; logic n; bit ok; logic [31:0] exp_d;
`ifdef FP_MAX_POOL_RELU_EN
    exp_d = PZ;
`else
    exp_d = N1;
`endif
    win = '{N3, N1, NINF, N2};
    send_window(0);
    collect(0, d, i, n, ok);
    checks++;
    if (!ok || d !== exp_d || i !== 2'd1 || n !== 1'b0) begin
      errors++;
      $display("FAIL relu_window: got ok=%b d=%h i=%0d n=%b want d=%h i=1 n=0",
               ok, d, i, n, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] i; logic n; bit ok;
    logic [31:0] ed; logic [1:0] ei; logic en;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 4; k++) win[k] = {1'b0, 8'(8'h7F + w), 23'(k * 1000)};
      model(ed, ei, en);
      send_window(0);
      collect(0, d, i, n, ok);
      checks++;
      if (!ok || d !== ed || i !== ei || n !== en || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b w=%0d: got ok=%b d=%h i=%0d n=%b r=%b want d=%h i=%0d n=%b r=1",
                 w, ok, d, i, n, in_ready, ed, ei, en);
      end
    end
  endtask

  function automatic logic [31:0] rand_sample();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       return {r[31], 8'hFF, r[22:1], 1'b1};
      1:       return {r[31], 31'h0};
      2:       return {r[31], 8'hFF, 23'h0};
      3, 4: begin
        case (r[1:0])
          2'd0:    return P1;
          2'd1:    return N1;
          2'd2:    return P2;
          default: return N2;
        endcase
      end
      default: return r;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] d; logic [1:0] i; logic n; bit ok;
    logic [31:0] ed; logic [1:0] ei; logic en;
    for (int w = 0; w < 60; w++) begin
      for (int k = 0; k < 4; k++) win[k] = rand_sample();
      model(ed, ei, en);
      send_window(2);
      collect($urandom_range(0, 3), d, i, n, ok);
      checks++;
      if (!ok || d !== ed || i !== ei || n !== en) begin
        errors++;
        $display("FAIL random w=%0d: got ok=%b d=%h i=%0d n=%b want d=%h i=%0d n=%b in=%h %h %h %h",
                 w, ok, d, i, n, ed, ei, en, win[0], win[1], win[2], win[3]);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_ties();
    test_nan();
    test_backpressure();
    test_mid_reset();
    test_relu();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
